// File: rtl/mips_load_run_ctrl.sv
// Load/run sequencer for the single-cycle MIPS core: streams words into instruction/data memory, then runs the core for a bounded budget.
// Optional LOADER_CHECKSUM_EN: adds a wrapping sum of the payload words written since the last LOAD header.
module mips_load_run_ctrl #(
  parameter int ADDR_W          = 10,
  parameter int BUDGET_W        = 20,
  parameter int CORE_RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              enable,
  output logic              core_rst,
  output logic              inst_we,
  output logic              data_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              run_done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam int RC_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(CORE_RST_CYCLES - 1);

  localparam logic [1:0] CMD_LOAD_I = 2'b00;
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_RUN    = 2'b10;
  localparam logic [1:0] CMD_ABORT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CRST, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                tgt_q, tgt_d;
  logic [BUDGET_W-1:0] budget_q, budget_d;
  logic [RC_W-1:0]     rc_q, rc_d;
  logic                s_ready_q, s_ready_d;
  logic                enable_q, enable_d;
  logic                core_rst_q, core_rst_d;
  logic                inst_we_q, inst_we_d;
  logic                data_we_q, data_we_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                run_done_q, run_done_d;
  logic                err_q, err_d;
  logic                acc;
  logic [1:0]          cmd;

  assign acc = s_valid & s_ready_q;
  assign cmd = s_data[31:30];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    budget_d   = budget_q;
    rc_d       = rc_q;
    inst_we_d  = 1'b0;
    data_we_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    run_done_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          case (cmd)
            CMD_LOAD_I, CMD_LOAD_D: begin
              state_d = S_LOAD;
              tgt_d   = (cmd == CMD_LOAD_D);
              addr_d  = s_data[ADDR_W-1:0];
              cnt_d   = s_data[ADDR_W+15:16];
            end
            CMD_RUN: begin
              state_d  = S_CRST;
              budget_d = s_data[BUDGET_W-1:0];
              rc_d     = '0;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (acc) begin
          wr_addr_d = addr_q;
          wr_data_d = s_data;
          inst_we_d = ~tgt_q;
          data_we_d = tgt_q;
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_IDLE;
        end
      end
      S_CRST: begin
        rc_d = rc_q + 1'b1;
        if (rc_q == RC_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (acc && cmd == CMD_ABORT) begin
          state_d    = S_IDLE;
          run_done_d = 1'b1;
        end else begin
          if (acc) err_d = 1'b1;
          // A zero budget never counts down: the run only ends on ABORT.
          if (budget_q != '0) begin
            budget_d = budget_q - 1'b1;
            if (budget_q == BUDGET_W'(1)) begin
              state_d    = S_IDLE;
              run_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    s_ready_d  = (state_d != S_CRST);
    enable_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
    core_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      tgt_q      <= 1'b0;
      budget_q   <= '0;
      rc_q       <= '0;
      s_ready_q  <= 1'b0;
      enable_q   <= 1'b1;
      core_rst_q <= 1'b1;
      inst_we_q  <= 1'b0;
      data_we_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      run_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      budget_q   <= budget_d;
      rc_q       <= rc_d;
      s_ready_q  <= s_ready_d;
      enable_q   <= enable_d;
      core_rst_q <= core_rst_d;
      inst_we_q  <= inst_we_d;
      data_we_q  <= data_we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      run_done_q <= run_done_d;
      err_q      <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (acc && state_q == S_IDLE && !s_data[31]) csum_d = '0;
    else if (acc && state_q == S_LOAD)           csum_d = csum_q + s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign s_ready  = s_ready_q;
  assign enable   = enable_q;
  assign core_rst = core_rst_q;
  assign inst_we  = inst_we_q;
  assign data_we  = data_we_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);
  assign run_done = run_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mips_load_run_ctrl.sv
// Directed-vector bench for mips_load_run_ctrl: load, wrap, run, abort and async reset.
module tb_mips_load_run_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        enable, core_rst, inst_we, data_we, busy, run_done, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] checksum;

  int n_vec  = 0;
  int n_miss = 0;

  mips_load_run_ctrl #(.ADDR_W(10), .BUDGET_W(20), .CORE_RST_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .enable(enable), .core_rst(core_rst),
    .inst_we(inst_we), .data_we(data_we),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .run_done(run_done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one word (or idle) for exactly one clock; returns at the following negedge.
  task automatic drive(input logic v, input logic [31:0] d);
    if (v) chk("s_ready_before_word", {31'd0, s_ready}, 32'd1);
    s_valid = v;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 32'd0;
  endtask

  localparam logic [31:0] WA = 32'hDEAD_BEEF;
  localparam logic [31:0] WB = 32'h1234_5678;
  localparam logic [31:0] WC = 32'hCAFE_F00D;
  localparam logic [31:0] W0 = 32'hFFFF_FFF0;
  localparam logic [31:0] W1 = 32'h0000_0020;
  localparam logic [31:0] W5 = 32'hA5A5_0001;

  logic [31:0] exp_sum;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0;
    #1;
    chk("rst_enable",   {31'd0, enable},   32'd1);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_s_ready",  {31'd0, s_ready},  32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_hold_busy",    {31'd0, busy},    32'd0);
    chk("rst_checksum",     checksum,         32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_enable",  {31'd0, enable},  32'd1);

    // LOAD_I 3 words at 0x010
    drive(1'b1, 32'h0002_0010);
    chk("li_hdr_busy", {31'd0, busy},    32'd1);
    chk("li_hdr_we",   {31'd0, inst_we}, 32'd0);
    drive(1'b1, WA);
    chk("li_a_we",   {31'd0, inst_we}, 32'd1);
    chk("li_a_dwe",  {31'd0, data_we}, 32'd0);
    chk("li_a_addr", {22'd0, wr_addr}, 32'h010);
    chk("li_a_data", wr_data, WA);
    drive(1'b1, WB);
    chk("li_b_we",   {31'd0, inst_we}, 32'd1);
    chk("li_b_addr", {22'd0, wr_addr}, 32'h011);
    chk("li_b_data", wr_data, WB);
    chk("li_b_busy", {31'd0, busy},    32'd1);
    drive(1'b1, WC);
    chk("li_c_we",   {31'd0, inst_we}, 32'd1);
    chk("li_c_dwe",  {31'd0, data_we}, 32'd0);
    chk("li_c_addr", {22'd0, wr_addr}, 32'h012);
    chk("li_c_data", wr_data, WC);
    chk("li_c_busy", {31'd0, busy},    32'd0);
    drive(1'b0, 32'd0);
    chk("li_after_we", {31'd0, inst_we}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = WA + WB + WC;
`else
    exp_sum = 32'd0;
`endif
    chk("li_checksum", checksum, exp_sum);

    // LOAD_D 2 words starting at 0x3FF, address wraps
    drive(1'b1, 32'h4001_03FF);
    drive(1'b1, W0);
    chk("ld_0_dwe",  {31'd0, data_we}, 32'd1);
    chk("ld_0_iwe",  {31'd0, inst_we}, 32'd0);
    chk("ld_0_addr", {22'd0, wr_addr}, 32'h3FF);
    chk("ld_0_data", wr_data, W0);
    drive(1'b1, W1);
    chk("ld_1_dwe",  {31'd0, data_we}, 32'd1);
    chk("ld_1_addr", {22'd0, wr_addr}, 32'h000);
    chk("ld_1_data", wr_data, W1);
    chk("ld_1_busy", {31'd0, busy},    32'd0);
    drive(1'b0, 32'd0);
    chk("ld_after_dwe", {31'd0, data_we}, 32'd0);
    chk("ld_err",       {31'd0, err},     32'd0);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = W0 + W1;
`else
    exp_sum = 32'd0;
`endif
    chk("ld_checksum", checksum, exp_sum);

    // RUN budget 5
    drive(1'b1, 32'h8000_0005);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("r5_crst%0d_core_rst", i), {31'd0, core_rst}, 32'd1);
      chk($sformatf("r5_crst%0d_enable", i),   {31'd0, enable},   32'd0);
      chk($sformatf("r5_crst%0d_s_ready", i),  {31'd0, s_ready},  32'd0);
      drive(1'b0, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("r5_run%0d_core_rst", i), {31'd0, core_rst}, 32'd0);
      chk($sformatf("r5_run%0d_enable", i),   {31'd0, enable},   32'd0);
      chk($sformatf("r5_run%0d_done", i),     {31'd0, run_done}, 32'd0);
      drive(1'b0, 32'd0);
    end
    chk("r5_done",     {31'd0, run_done}, 32'd1);
    chk("r5_enable",   {31'd0, enable},   32'd1);
    chk("r5_core_rst", {31'd0, core_rst}, 32'd1);
    chk("r5_busy",     {31'd0, busy},     32'd0);
    drive(1'b0, 32'd0);
    chk("r5_done_clear", {31'd0, run_done}, 32'd0);

    // RUN unbounded, stray LOAD header, then ABORT
    drive(1'b1, 32'h8000_0000);
    drive(1'b0, 32'd0);
    drive(1'b0, 32'd0);
    chk("r0_running", {31'd0, core_rst}, 32'd0);
    drive(1'b1, 32'h0002_0010);
    chk("r0_err",      {31'd0, err},      32'd1);
    chk("r0_no_we",    {31'd0, inst_we},  32'd0);
    chk("r0_core_rst", {31'd0, core_rst}, 32'd0);
    repeat (8) drive(1'b0, 32'd0);
    chk("r0_still_busy", {31'd0, busy},     32'd1);
    chk("r0_no_done",    {31'd0, run_done}, 32'd0);
    drive(1'b1, 32'hC000_0000);
    chk("abort_done",   {31'd0, run_done}, 32'd1);
    chk("abort_busy",   {31'd0, busy},     32'd0);
    chk("abort_enable", {31'd0, enable},   32'd1);
    chk("abort_err",    {31'd0, err},      32'd1);

    // Async reset after 1 of 4 words
    drive(1'b1, 32'h0003_0020);
    drive(1'b1, WA);
    chk("mid_we",   {31'd0, inst_we}, 32'd1);
    chk("mid_addr", {22'd0, wr_addr}, 32'h020);
    rst = 1'b1;
    #1;
    chk("arst_we",       {31'd0, inst_we},  32'd0);
    chk("arst_addr",     {22'd0, wr_addr},  32'd0);
    chk("arst_data",     wr_data,           32'd0);
    chk("arst_busy",     {31'd0, busy},     32'd0);
    chk("arst_err",      {31'd0, err},      32'd0);
    chk("arst_s_ready",  {31'd0, s_ready},  32'd0);
    chk("arst_enable",   {31'd0, enable},   32'd1);
    chk("arst_core_rst", {31'd0, core_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h4000_0005);
    drive(1'b1, W5);
    chk("fresh_dwe",  {31'd0, data_we}, 32'd1);
    chk("fresh_iwe",  {31'd0, inst_we}, 32'd0);
    chk("fresh_addr", {22'd0, wr_addr}, 32'h005);
    chk("fresh_data", wr_data, W5);
    chk("fresh_busy", {31'd0, busy},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
